// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, RV32I funct3 codes, load mask codes and request decode helpers
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] LM_B  = 4'b0000;
  localparam logic [3:0] LM_H  = 4'b0001;
  localparam logic [3:0] LM_W  = 4'b0010;
  localparam logic [3:0] LM_BU = 4'b0011;
  localparam logic [3:0] LM_HU = 4'b0100;
  function automatic logic [3:0] load_mask(input logic [2:0] f3);
    return f3 == F3_H ? LM_H : f3 == F3_W ? LM_W : f3 == F3_BU ? LM_BU : f3 == F3_HU ? LM_HU : LM_B;
  endfunction
  function automatic logic legal_f3(input logic ld, input logic [2:0] f3);
    return ld ? (f3 != 3'b011 && f3[2:1] != 2'b11) : (f3 < 3'b011);
  endfunction
  function automatic logic bad_align(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b01 ? a[0] : f3[1:0] == 2'b10 ? |a : 1'b0;
  endfunction
  function automatic logic [31:0] nat_align(input logic [2:0] f3, input logic [31:0] a);
    return f3[1:0] == 2'b10 ? {a[31:2], 2'b00} : f3[1:0] == 2'b01 ? {a[31:1], 1'b0} : a;
  endfunction
endpackage

// File: rtl/lsu_store_align.sv
// lsu_store_align: steers store data onto byte lanes and builds the byte-enable mask
module lsu_store_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  mask,
  output logic [31:0] lane_wdata
);
  // replicate the datum across all lanes; the mask selects which lanes the memory writes
  always_comb begin
    mask = size == 2'b10 ? 4'b1111 : size == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b0001 << addr;
    lane_wdata = size == 2'b10 ? wdata : size == 2'b01 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit FSM; define LSU_MISALIGN_EXC_EN to report misaligned requests instead of aligning them
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        misaligned,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_cs_n,
  output logic        dmem_rd,
  output logic [3:0]  dmem_mask,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_rdata
);
  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0] f3_q, f3_d;
  logic load_q, load_d, rv_q, rv_d, fault_q, fault_d, mis_q, mis_d, cs_n_q, cs_n_d;
  logic [3:0] st_mask;
  lsu_store_align u_align (
    .size(f3_q[1:0]),
    .addr(addr_q[1:0]),
    .wdata(wdata_q),
    .mask(st_mask),
    .lane_wdata(dmem_wdata)
  );
  // next-state and registered-output logic; rv_d is set exactly on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d = f3_q;
    load_d = load_q;
    rv_d = 1'b0;
    fault_d = 1'b0;
    mis_d = 1'b0;
    cs_n_d = cs_n_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (!legal_f3(req_load, req_funct3)) begin
          state_d = DONE;
          rv_d = 1'b1;
          fault_d = 1'b1;
        end
`ifdef LSU_MISALIGN_EXC_EN
        else if (bad_align(req_funct3, req_addr[1:0])) begin
          state_d = DONE;
          rv_d = 1'b1;
          mis_d = 1'b1;
        end
`endif
        else begin
          state_d = ACCESS;
          cs_n_d = 1'b0;
          addr_d = nat_align(req_funct3, req_addr);
          f3_d = req_funct3;
          load_d = req_load;
          wdata_d = req_wdata;
        end
      end
      ACCESS: if (!load_q || dmem_valid) begin
        state_d = DONE;
        rv_d = 1'b1;
        cs_n_d = 1'b1;
        rdata_d = load_q ? dmem_rdata : rdata_q;
      end else begin
        state_d = WAIT;
        cnt_d = 8'd1;
      end
      WAIT: if (dmem_valid || cnt_q == CNT_LAST) begin
        state_d = DONE;
        rv_d = 1'b1;
        cs_n_d = 1'b1;
        fault_d = !dmem_valid;
        rdata_d = dmem_valid ? dmem_rdata : rdata_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d = 8'd0;
      end
    endcase
  end
  // state register; reset aborts any access in flight without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      f3_q <= 3'd0;
      load_q <= 1'b0;
      rv_q <= 1'b0;
      fault_q <= 1'b0;
      mis_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q <= f3_d;
      load_q <= load_d;
      rv_q <= rv_d;
      fault_q <= fault_d;
      mis_q <= mis_d;
      cs_n_q <= cs_n_d;
    end
  end
  assign stall = (state_q == IDLE && req_valid) || state_q == ACCESS || state_q == WAIT;
  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign misaligned = mis_q;
  assign dmem_addr = addr_q;
  assign dmem_rd = load_q;
  assign dmem_cs_n = cs_n_q;
  assign dmem_mask = load_q ? load_mask(f3_q) : st_mask;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed transactions checked every cycle against a transaction-level schedule model
module tb_lsu;
  localparam int WAIT_MAX = 8;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_load = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic stall, resp_valid, resp_fault, misaligned, dmem_cs_n, dmem_rd, dmem_valid = 0;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0] dmem_mask;
  lsu #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .misaligned(misaligned),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_cs_n(dmem_cs_n), .dmem_rd(dmem_rd),
    .dmem_mask(dmem_mask), .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  logic exp_stall, exp_cs_n, exp_rv, exp_fault, exp_mis, exp_rd;
  logic [31:0] exp_addr, exp_wdata, m_rdata;
  logic [3:0] exp_mask;
  int cs_cnt, rv_cnt;
  logic [31:0] last_addr, last_wdata;
  logic [3:0] last_mask;
  logic last_rd, last_fault, last_mis;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("dmem_cs_n", 32'(dmem_cs_n), 32'(exp_cs_n));
      chk("resp_rdata", resp_rdata, m_rdata);
      if (exp_rv) begin
        chk("resp_fault", 32'(resp_fault), 32'(exp_fault));
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
      end
      if (!exp_cs_n) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_rd", 32'(dmem_rd), 32'(exp_rd));
        chk("dmem_mask", 32'(dmem_mask), 32'(exp_mask));
        if (!exp_rd) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
    if (!dmem_cs_n) begin
      cs_cnt++;
      last_addr = dmem_addr;
      last_wdata = dmem_wdata;
      last_mask = dmem_mask;
      last_rd = dmem_rd;
    end
    if (resp_valid) begin
      rv_cnt++;
      last_fault = resp_fault;
      last_mis = misaligned;
    end
  end
  task automatic idle();
    req_valid = 0;
    dmem_valid = 0;
    exp_stall = 0;
    exp_cs_n = 1;
    exp_rv = 0;
  endtask
  // one request: the model derives the whole cycle schedule from the request and memory latency d
  task automatic txn(input bit ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int d, input logic [31:0] rdv, input int abort_at);
    bit ok, mis, no_acc, flt;
    logic [1:0] sz;
    logic [31:0] ea;
    int n;
    sz = f3[1:0];
    ok = ld ? !(f3 == 3 || f3 == 6 || f3 == 7) : f3 < 3;
    mis = ok && ((sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00));
`ifdef LSU_MISALIGN_EXC_EN
    no_acc = !ok || mis;
    ea = a;
`else
    no_acc = !ok;
    mis = 0;
    ea = sz == 2 ? a & ~32'h3 : sz == 1 ? a & ~32'h1 : a;
`endif
    n = no_acc ? 0 : !ld ? 1 : d < WAIT_MAX ? d + 1 : WAIT_MAX;
    flt = !ok || (ld && !no_acc && d >= WAIT_MAX);
    cs_cnt = 0;
    rv_cnt = 0;
    req_valid = 1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
    dmem_valid = 0;
    exp_stall = 1; exp_cs_n = 1; exp_rv = 0;
    @(posedge clk) #1;
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    exp_addr = ea;
    exp_rd = ld;
    case (f3)
      3'd1: exp_mask = ld ? 4'b0001 : 4'b0011 << ea[1:0];
      3'd2: exp_mask = ld ? 4'b0010 : 4'b1111;
      3'd4: exp_mask = 4'b0011;
      3'd5: exp_mask = 4'b0100;
      default: exp_mask = ld ? 4'b0000 : 4'b0001 << ea[1:0];
    endcase
    exp_wdata = sz == 0 ? {4{wd[7:0]}} : sz == 1 ? {2{wd[15:0]}} : wd;
    for (int k = 0; k < n; k++) begin
      dmem_valid = ld && k == d;
      dmem_rdata = k == d ? rdv : $urandom;
      exp_stall = 1; exp_cs_n = 0;
      if (k == abort_at) rst = 1;
      @(posedge clk) #1;
      if (k == abort_at) begin
        rst = 0;
        idle();
        m_rdata = 0;
        @(posedge clk) #1;
        return;
      end
    end
    dmem_valid = 0;
    exp_stall = 0; exp_cs_n = 1; exp_rv = 1; exp_fault = flt; exp_mis = mis;
    if (ld && !no_acc && !flt) m_rdata = rdv;
    req_valid = 1; req_load = $urandom; req_funct3 = 3'd2; req_addr = 32'h80;
    @(posedge clk) #1;
    idle();
    @(posedge clk) #1;
  endtask
  initial begin
    idle();
    m_rdata = 0;
    @(posedge clk) #1;
    chk_en = 1;
    @(posedge clk) #1;
    rst = 0;
    chk("rst_rdata", resp_rdata, 32'h0);
    @(posedge clk) #1;
    txn(1, 3'd2, 32'h10, 0, 0, 32'hDEADBEEF, -1);
    chk("lw_cs_cycles", cs_cnt, 1);
    chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
    txn(0, 3'd0, 32'h13, 32'h000000A5, 0, 0, -1);
    chk("sb_mask", 32'(last_mask), 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb_cs_cycles", cs_cnt, 1);
    chk("sb_rd", 32'(last_rd), 0);
    chk("sb_keeps_rdata", resp_rdata, 32'hDEADBEEF);
    txn(1, 3'd1, 32'h22, 0, 3, 32'hFFFF8001, -1);
    chk("lh_cs_cycles", cs_cnt, 4);
    chk("lh_rdata", resp_rdata, 32'hFFFF8001);
    txn(1, 3'd0, 32'h31, 0, 99, 0, -1);
    chk("to_cs_cycles", cs_cnt, 8);
    chk("to_fault", 32'(last_fault), 1);
    chk("to_keeps_rdata", resp_rdata, 32'hFFFF8001);
    txn(0, 3'd1, 32'h46, 32'h1234BEEF, 0, 0, -1);
    chk("sh_mask", 32'(last_mask), 32'hC);
    chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
    txn(0, 3'd2, 32'h02, 32'hCAFEF00D, 0, 0, -1);
`ifdef LSU_MISALIGN_EXC_EN
    chk("sw_mis_cs_cycles", cs_cnt, 0);
    chk("sw_mis_flag", 32'(last_mis), 1);
`else
    chk("sw_mis_addr", last_addr, 32'h0);
    chk("sw_mis_mask", 32'(last_mask), 32'hF);
    chk("sw_mis_cs_cycles", cs_cnt, 1);
`endif
    txn(1, 3'd3, 32'h40, 0, 0, 32'h11111111, -1);
    chk("ill_ld_cs_cycles", cs_cnt, 0);
    chk("ill_ld_fault", 32'(last_fault), 1);
    txn(0, 3'd4, 32'h44, 32'h55, 0, 0, -1);
    chk("ill_st_cs_cycles", cs_cnt, 0);
    txn(1, 3'd5, 32'h51, 0, 1, 32'h0000ABCD, -1);
    txn(1, 3'd2, 32'h60, 0, WAIT_MAX - 1, 32'h76543210, -1);
    chk("lw_last_wait_rdata", resp_rdata, 32'h76543210);
    txn(1, 3'd4, 32'h63, 0, 2, 32'h000000F0, -1);
    txn(1, 3'd2, 32'h70, 0, 99, 32'h0, 2);
    chk("abort_rv", rv_cnt, 0);
    chk("abort_rdata", resp_rdata, 32'h0);
    txn(1, 3'd2, 32'h74, 0, 0, 32'h11223344, -1);
    chk("post_abort_rdata", resp_rdata, 32'h11223344);
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 8: maximum cycles spent in WAIT before an access fault; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports req_valid in 1 (memory instruction present), req_load in 1 (1=load, 0=store), req_funct3 in 3 (RV32I funct3).
REQ-005 SHALL have ports req_addr in 32 (effective byte address) and req_wdata in 32 (rs2 store data, right-aligned).
REQ-006 SHALL have ports stall out 1 (hold pipeline), resp_valid out 1 (one-cycle completion pulse), resp_rdata out 32 (load result).
REQ-007 SHALL have ports resp_fault out 1 (timeout, qualified by resp_valid) and misaligned out 1 (qualified by resp_valid).
REQ-008 SHALL have memory-side ports dmem_addr out 32, dmem_wdata out 32, dmem_cs_n out 1 (active-low select), dmem_rd out 1 (1=read), dmem_mask out 4.
REQ-009 SHALL have memory-side inputs dmem_valid in 1 (read data valid) and dmem_rdata in 32 (extended load data).

Function
REQ-010 SHALL implement the FSM states IDLE, ACCESS, WAIT and DONE.
REQ-011 IDLE: dmem_cs_n=1; on req_valid with legal, aligned request, latch addr/funct3/load/wdata and go to ACCESS; otherwise stay.
REQ-012 ACCESS, load: dmem_cs_n=0, dmem_rd=1; dmem_valid=1 captures dmem_rdata into resp_rdata and goes to DONE; else go to WAIT, counter=1.
REQ-013 ACCESS, store: dmem_cs_n=0, dmem_rd=0 for exactly one cycle (memory writes on that edge), then go to DONE; stores never enter WAIT.
REQ-014 WAIT: keep read asserted and increment counter; dmem_valid goes to DONE with capture; counter==WAIT_MAX-1 without valid goes to DONE with resp_fault=1.
REQ-015 DONE: resp_valid=1, stall=0, dmem_cs_n=1; always goes to IDLE; req_valid in DONE is ignored.
REQ-016 stall SHALL equal (IDLE and req_valid) or ACCESS or WAIT, combinationally; loads take 2 cycles minimum, stores exactly 2.
REQ-017 Load dmem_mask codes: LB 0000, LH 0001, LW 0010, LBU 0011, LHU 0100.
REQ-018 Store dmem_mask: SB 0001<<addr[1:0], SH 0011<<{addr[1],1'b0}, SW 1111; dmem_wdata replicated: SB {4{byte}}, SH {2{half}}, SW unchanged.
REQ-019 dmem_addr SHALL be the latched byte address, passed through unmodified except per REQ-024.
REQ-020 Illegal funct3 (load 011/110/111, store >=011) SHALL go IDLE->DONE with no memory access, resp_rdata unchanged, resp_fault=1.
REQ-021 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00.
REQ-022 resp_rdata SHALL hold its last captured value until the next capture; stores and faults do not modify it.

Reset
REQ-023 On rst: state=IDLE, counter=0, resp_rdata=0, resp_valid=0, resp_fault=0, misaligned=0, dmem_cs_n=1, latched fields 0; reset mid-ACCESS/WAIT aborts silently with no resp_valid and no write.

Configuration
REQ-024 Macro LSU_MISALIGN_EXC_EN defined: misaligned request goes IDLE->DONE, no access, misaligned=1 with resp_valid; undefined: misaligned tied 0, low address bits forced to natural alignment, access performed.

Structure
REQ-025 Package lsu_pkg SHALL hold the state enum, funct3 constants (F3_B/H/W/BU/HU) and load mask codes.
REQ-026 Store lane steering (REQ-018) SHALL be a combinational sub-module lsu_store_align; the FSM stays in lsu.

Verification
REQ-027 LW addr 0x10, dmem_valid same cycle, rdata 0xDEADBEEF -> stall 1 cycle, resp_valid next, resp_rdata=0xDEADBEEF.
REQ-028 SB addr 0x13, wdata 0x000000A5 -> one cycle cs_n=0 rd=0, mask 1000, dmem_wdata 0xA5A5A5A5, resp_valid next cycle.
REQ-029 LH with dmem_valid delayed 3 cycles -> stall 4 cycles, capture on valid; WAIT_MAX=8 with no valid -> resp_fault=1 after 8 cycles in ACCESS+WAIT.
REQ-030 SW addr 0x02: macro defined -> no cs_n pulse, misaligned=1; undefined -> write at 0x00 mask 1111.
REQ-031 rst asserted in WAIT -> next cycle IDLE, cs_n=1, no resp_valid, resp_rdata=0.
